// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I/RV64I decode stage with a two-entry skid buffer
// Decoded fields are registered; a load-use check can hold in_ready against buffered loads.
module decode_stage #(
  parameter int XLEN           = 32,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_mode,
  output logic            out_a_sel,
  output logic            out_b_sel,
  output logic [1:0]      out_write_sel,
  output logic            out_reg_we,
  output logic            out_mem_en,
  output logic [3:0]      out_ram_mode,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic [2:0]      out_br_type,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_PC4 = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_mode;
    logic            a_sel;
    logic            b_sel;
    logic [1:0]      write_sel;
    logic            reg_we;
    logic            mem_en;
    logic [3:0]      ram_mode;
    logic            is_branch;
    logic            is_jump;
    logic [2:0]      br_type;
    logic            illegal;
  } entry_t;

  entry_t dec;
  entry_t head;
  entry_t skid;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       rdy_q;
  logic       hazard;
  logic       accept;
  logic       handshake;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [4:0]        rs1_f;
  logic [4:0]        rs2_f;
  logic [4:0]        rd_f;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   imm_s;
  logic [XLEN-1:0]   imm_b;
  logic [XLEN-1:0]   imm_u;
  logic [XLEN-1:0]   imm_j;
  logic signed [31:0] u_raw;
  logic              rs1_used;
  logic              rs2_used;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign rs1_f  = in_inst[19:15];
  assign rs2_f  = in_inst[24:20];
  assign rd_f   = in_inst[11:7];

  assign imm_i = {{(XLEN-11){in_inst[31]}}, in_inst[30:20]};
  assign imm_s = {{(XLEN-11){in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
  assign imm_b = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign u_raw = {in_inst[31:12], 12'b0};
  assign imm_u = XLEN'(u_raw);

  assign rs1_used = opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
  assign rs2_used = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.rs1    = rs1_f;
    dec.rs2    = rs2_f;
    dec.rd     = rd_f;
    dec.reg_we = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.alu_mode = {funct3, in_inst[30]};
      end
      OPC_OP_IMM: begin
        dec.b_sel    = 1'b1;
        dec.imm      = imm_i;
        // only the shift-right encoding uses bit 30 as an arith/logical select
        dec.alu_mode = {funct3, (funct3 == 3'b101) & in_inst[30]};
      end
      OPC_LOAD: begin
        dec.b_sel     = 1'b1;
        dec.imm       = imm_i;
        dec.write_sel = WSEL_MEM;
        dec.mem_en    = 1'b1;
        dec.ram_mode  = {funct3, 1'b0};
      end
      OPC_STORE: begin
        dec.reg_we   = 1'b0;
        dec.b_sel    = 1'b1;
        dec.imm      = imm_s;
        dec.mem_en   = 1'b1;
        dec.ram_mode = {funct3, 1'b1};
        dec.rd       = 5'd0;
      end
      OPC_BRANCH: begin
        dec.reg_we    = 1'b0;
        dec.a_sel     = 1'b1;
        dec.b_sel     = 1'b1;
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        dec.br_type   = funct3;
        dec.rd        = 5'd0;
      end
      OPC_JALR: begin
        dec.b_sel     = 1'b1;
        dec.imm       = imm_i;
        dec.write_sel = WSEL_PC4;
        dec.is_jump   = 1'b1;
      end
      OPC_JAL: begin
        dec.a_sel     = 1'b1;
        dec.b_sel     = 1'b1;
        dec.imm       = imm_j;
        dec.write_sel = WSEL_PC4;
        dec.is_jump   = 1'b1;
      end
      OPC_LUI: begin
        dec.b_sel = 1'b1;
        dec.imm   = imm_u;
        dec.rs1   = 5'd0;
      end
      OPC_AUIPC: begin
        dec.a_sel = 1'b1;
        dec.b_sel = 1'b1;
        dec.imm   = imm_u;
      end
      default: begin
        dec.illegal = 1'b1;
        dec.reg_we  = 1'b0;
      end
    endcase
    if (dec.rd == 5'd0) begin
      dec.reg_we = 1'b0;
    end
    if (dec.write_sel == WSEL_ALU) begin
      dec.write_sel = WSEL_ALU;
    end
  end

  function automatic logic load_blocks(input entry_t e, input logic [4:0] r1, input logic [4:0] r2,
                                       input logic u1, input logic u2);
    logic pending;
    pending = e.mem_en & ~e.ram_mode[0] & (e.rd != 5'd0);
    return pending & ((u1 & (e.rd == r1)) | (u2 & (e.rd == r2)));
  endfunction

  generate
    if (LOAD_USE_STALL != 0) begin : g_hazard
      assign hazard = ((state != S_EMPTY) & load_blocks(head, rs1_f, rs2_f, rs1_used, rs2_used)) |
                      ((state == S_TWO) & load_blocks(skid, rs1_f, rs2_f, rs1_used, rs2_used));
    end else begin : g_no_hazard
      assign hazard = 1'b0;
    end
  endgenerate

  // rdy_q tracks buffer space; the hazard, flush and reset terms stay combinational
  assign in_ready  = rdy_q & ~rst & ~flush & ~hazard;
  assign out_valid = (state != S_EMPTY) & ~rst;
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  always_comb begin
    state_nx = state;
    case (state)
      S_EMPTY: if (accept) state_nx = S_ONE;
      S_ONE: begin
        if (accept && !handshake) begin
          state_nx = S_TWO;
        end else if (!accept && handshake) begin
          state_nx = S_EMPTY;
        end
      end
      S_TWO:   if (handshake) state_nx = S_ONE;
      default: state_nx = S_EMPTY;
    endcase
    if (flush) begin
      state_nx = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
      rdy_q <= 1'b1;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= (state_nx != S_TWO);
      if (!flush) begin
        case (state)
          S_EMPTY: if (accept) head <= dec;
          S_ONE: begin
            if (accept && handshake) begin
              head <= dec;
            end else if (accept) begin
              skid <= dec;
            end
          end
          S_TWO:   if (handshake) head <= skid;
          default: ;
        endcase
      end
    end
  end

  assign out_pc        = head.pc;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_imm       = head.imm;
  assign out_alu_mode  = head.alu_mode;
  assign out_a_sel     = head.a_sel;
  assign out_b_sel     = head.b_sel;
  assign out_write_sel = head.write_sel;
  assign out_reg_we    = head.reg_we;
  assign out_mem_en    = head.mem_en;
  assign out_ram_mode  = head.ram_mode;
  assign out_is_branch = head.is_branch;
  assign out_is_jump   = head.is_jump;
  assign out_br_type   = head.br_type;
  assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
// Two instances share stimulus: 32-bit with load-use stall, 64-bit without.
module tb_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [3:0]  alu;
    logic        a_sel;
    logic        b_sel;
    logic [1:0]  wsel;
    logic        we;
    logic        mem;
    logic [3:0]  ram;
    logic        br;
    logic        jmp;
    logic [2:0]  brt;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        a_ready, a_valid, a_asel, a_bsel, a_we, a_mem, a_br, a_jmp, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [3:0]  a_alu, a_ram;
  logic [1:0]  a_wsel;
  logic [2:0]  a_brt;

  logic        b_ready, b_valid, b_asel, b_bsel, b_we, b_mem, b_br, b_jmp, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [3:0]  b_alu, b_ram;
  logic [1:0]  b_wsel;
  logic [2:0]  b_brt;

  ent_t act_a, act_b;
  ent_t q0[$];
  ent_t q1[$];
  bit   known[2];
  bit   zero[2];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .LOAD_USE_STALL(1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(a_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
    .out_alu_mode(a_alu), .out_a_sel(a_asel), .out_b_sel(a_bsel), .out_write_sel(a_wsel),
    .out_reg_we(a_we), .out_mem_en(a_mem), .out_ram_mode(a_ram), .out_is_branch(a_br),
    .out_is_jump(a_jmp), .out_br_type(a_brt), .out_illegal(a_ill)
  );

  decode_stage #(.XLEN(64), .LOAD_USE_STALL(0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
    .out_alu_mode(b_alu), .out_a_sel(b_asel), .out_b_sel(b_bsel), .out_write_sel(b_wsel),
    .out_reg_we(b_we), .out_mem_en(b_mem), .out_ram_mode(b_ram), .out_is_branch(b_br),
    .out_is_jump(b_jmp), .out_br_type(b_brt), .out_illegal(b_ill)
  );

  assign act_a = {32'b0, a_pc, a_rs1, a_rs2, a_rd, 32'b0, a_imm, a_alu, a_asel, a_bsel, a_wsel,
                  a_we, a_mem, a_ram, a_br, a_jmp, a_brt, a_ill};
  assign act_b = {b_pc, b_rs1, b_rs2, b_rd, b_imm, b_alu, b_asel, b_bsel, b_wsel,
                  b_we, b_mem, b_ram, b_br, b_jmp, b_brt, b_ill};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Reference decoder: sign extension via signed casts of the assembled immediates
  function automatic ent_t mdec(input logic [31:0] i, input logic [63:0] pc);
    ent_t e;
    logic [2:0] f3;
    f3 = i[14:12];
    e = '0;
    e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.we = 1'b1;
    case (i[6:0])
      7'b0110011: e.alu = {f3, i[30]};
      7'b0010011: begin e.b_sel = 1; e.imm = 64'($signed(i[31:20])); e.alu = {f3, (f3 == 3'd5) ? i[30] : 1'b0}; end
      7'b0000011: begin e.b_sel = 1; e.imm = 64'($signed(i[31:20])); e.wsel = 2'b01; e.mem = 1; e.ram = {f3, 1'b0}; end
      7'b0100011: begin e.we = 0; e.b_sel = 1; e.imm = 64'($signed({i[31:25], i[11:7]})); e.mem = 1; e.ram = {f3, 1'b1}; e.rd = 0; end
      7'b1100011: begin e.we = 0; e.a_sel = 1; e.b_sel = 1; e.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
                        e.br = 1; e.brt = f3; e.rd = 0; end
      7'b1100111: begin e.b_sel = 1; e.imm = 64'($signed(i[31:20])); e.wsel = 2'b10; e.jmp = 1; end
      7'b1101111: begin e.a_sel = 1; e.b_sel = 1; e.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
                        e.wsel = 2'b10; e.jmp = 1; end
      7'b0110111: begin e.b_sel = 1; e.imm = 64'($signed({i[31:12], 12'b0})); e.rs1 = 0; end
      7'b0010111: begin e.a_sel = 1; e.b_sel = 1; e.imm = 64'($signed({i[31:12], 12'b0})); end
      default:    begin e.ill = 1; e.we = 0; end
    endcase
    if (e.rd == 0) e.we = 0;
    return e;
  endfunction

  task automatic model_cycle(input int k, input logic act_v, input logic act_rdy, input ent_t act);
    ent_t q[$];
    ent_t want;
    logic [63:0] m;
    logic u1, u2, hz, exp_v, exp_rdy;
    string tag;
    if (k == 0) q = q0; else q = q1;
    tag = (k == 0) ? "x32" : "x64";
    m = (k == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
    u1 = in_inst[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    u2 = in_inst[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    hz = 1'b0;
    foreach (q[j]) begin
      if (q[j].mem && !q[j].ram[0] && q[j].rd != 0 &&
          ((u1 && q[j].rd == in_inst[19:15]) || (u2 && q[j].rd == in_inst[24:20])))
        hz = 1'b1;
    end
    exp_rdy = !rst && !flush && q.size() < 2 && !(k == 0 && hz);
    exp_v   = !rst && q.size() > 0;
    if (known[k]) begin
      chk({tag, "_out_valid"}, 64'(act_v), 64'(exp_v));
      chk({tag, "_in_ready"}, 64'(act_rdy), 64'(exp_rdy));
      if (exp_v || zero[k]) begin
        want = exp_v ? q[0] : '0;
        want.pc &= m;
        want.imm &= m;
        n_chk++;
        if (act !== want) begin
          n_fail++;
          $display("FAIL %s_entry: got %h expected %h", tag, act, want);
        end
      end
    end
    if (rst) begin
      q.delete();
      zero[k]  = 1'b1;
      known[k] = 1'b1;
    end else if (known[k]) begin
      if (flush) begin
        q.delete();
      end else begin
        if (exp_v && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) begin
          q.push_back(mdec(in_inst, in_pc));
          zero[k] = 1'b0;
        end
      end
    end
    if (k == 0) q0 = q; else q1 = q;
  endtask

  always @(negedge clk) begin
    model_cycle(0, a_valid, a_ready, act_a);
    model_cycle(1, b_valid, b_ready, act_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [63:0] pc);
    int n;
    n = 0;
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    #1;
    while (!a_ready && n < 20) begin
      tick();
      n++;
    end
    chk("push_accept", 64'(a_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0;
    repeat (3) tick();
    chk("rst_valid", 64'(a_valid), 0);
    chk("rst_ready", 64'(a_ready), 0);
    chk("rst_imm", 64'(a_imm), 0);
    chk("rst_we", 64'(a_we), 0);

    rst = 0; out_ready = 1;
    push(32'h00500093, 64'h100);
    #1;
    chk("addi_valid", 64'(a_valid), 1);
    chk("addi_rd", 64'(a_rd), 1);
    chk("addi_imm", 64'(a_imm), 5);
    chk("addi_alu", 64'(a_alu), 0);
    chk("addi_bsel", 64'(a_bsel), 1);
    chk("addi_we", 64'(a_we), 1);
    tick();

    out_ready = 0;
    push(32'h00100093, 64'h200);
    push(32'h002083B3, 64'h204);
    in_valid = 1; in_inst = 32'h40208433; in_pc = 64'h208;
    #1;
    chk("full_ready", 64'(a_ready), 0);
    tick();
    in_valid = 0;
    #1;
    chk("full_head_pc", 64'(a_pc), 64'h200);
    out_ready = 1;
    tick(); #1;
    chk("drain1_pc", 64'(a_pc), 64'h204);
    chk("drain1_rd", 64'(a_rd), 7);
    tick(); #1;
    chk("drain2_valid", 64'(a_valid), 0);

    out_ready = 0;
    push(32'h00012283, 64'h300);
    in_valid = 1; in_inst = 32'h00128333; in_pc = 64'h304;
    #1;
    chk("lu_hold32", 64'(a_ready), 0);
    chk("lu_nohold64", 64'(b_ready), 1);
    tick(); #1;
    chk("lu_hold32_again", 64'(a_ready), 0);
    out_ready = 1;
    tick(); #1;
    chk("lu_release", 64'(a_ready), 1);
    tick();
    in_valid = 0;
    #1;
    chk("lu_add_valid", 64'(a_valid), 1);
    chk("lu_add_rd", 64'(a_rd), 6);
    repeat (3) tick();

    push(32'h4041D193, 64'h400); #1;
    chk("srai_alu", 64'(a_alu), 64'b1011);
    push(32'h40000113, 64'h404); #1;
    chk("addi_hi_alu", 64'(a_alu), 0);
    chk("addi_hi_imm", 64'(a_imm), 64'h400);
    push(32'hFE208CE3, 64'h408); #1;
    chk("beq_imm32", 64'(a_imm), 64'hFFFF_FFF8);
    chk("beq_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_brtype", 64'(a_brt), 0);
    chk("beq_we", 64'(a_we), 0);
    chk("beq_isbr", 64'(a_br), 1);
    tick();

    out_ready = 0;
    push(32'h00100093, 64'h500);
    push(32'h00200113, 64'h504);
    in_valid = 1; in_inst = 32'h00300193; in_pc = 64'h508; flush = 1;
    #1;
    chk("flush_ready", 64'(a_ready), 0);
    tick();
    flush = 0;
    #1;
    chk("flush_valid", 64'(a_valid), 0);
    chk("flush_ready_after", 64'(a_ready), 1);
    tick();
    in_valid = 0;
    #1;
    chk("flush_new_valid", 64'(a_valid), 1);
    chk("flush_new_pc", 64'(a_pc), 64'h508);
    out_ready = 1;
    tick();

    push(32'h0000007F, 64'h600); #1;
    chk("ill_flag", 64'(a_ill), 1);
    chk("ill_we", 64'(a_we), 0);
    chk("ill_mem", 64'(a_mem), 0);
    push(32'h00100013, 64'h604); #1;
    chk("x0_we", 64'(a_we), 0);
    push(32'h800000B7, 64'h608); #1;
    chk("lui_imm64", b_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", 64'(a_imm), 64'h8000_0000);
    chk("lui_rs1", 64'(a_rs1), 0);
    tick();

    out_ready = 0;
    push(32'h00012283, 64'h700);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rstmid_valid", 64'(a_valid), 0);
    chk("rstmid_mem", 64'(a_mem), 0);
    chk("rstmid_rd", 64'(a_rd), 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined, parametrised RISC-V RV32I/RV64I instruction decode stage. It sits between fetch and execute.
- It registers all control fields behind a two-entry skid buffer with valid/ready handshakes on both sides.
- It detects load-use hazards against buffered loads and supports a pipeline flush.
- Branch comparison is not done here: the branch type is passed downstream for execute to resolve.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; immediates are sign-extended to XLEN.
- LOAD_USE_STALL, 1, 1 = hold in_ready on a load-use hazard; 0 = no hazard check (execute forwards).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all buffered and incoming instructions.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute accepts this cycle.
- out_pc  out  XLEN  PC of the entry.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_mode  out  4  {funct3, alt}.
- out_a_sel  out  1  1 = PC as operand A.
- out_b_sel  out  1  1 = imm as operand B.
- out_write_sel  out  2  00 ALU, 01 memory, 10 PC+4.
- out_reg_we  out  1  register write enable.
- out_mem_en  out  1  memory access enable.
- out_ram_mode  out  4  {funct3, is_store}.
- out_is_branch, out_is_jump  out  1 each  control-flow flags.
- out_br_type  out  3  funct3 of the branch.
- out_illegal  out  1  unknown opcode.

Behaviour:
- Reset: state EMPTY; out_valid=0, in_ready=0 during reset; all out_* fields are 0; pending-load tags are cleared.
- Decode is combinational on in_inst and is captured on acceptance (in_valid && in_ready). Latency is 1 cycle when the buffer is EMPTY.
- Decode rules:
  - OP 0110011: alu={f3,i[30]}.
  - OP-IMM 0010011: b_sel=1; imm=I; alu={f3, f3==101 ? i[30] : 0}.
  - LOAD 0000011: b_sel=1; imm=I; write_sel=01; mem_en=1; ram_mode={f3,0}.
  - STORE 0100011: reg_we=0; b_sel=1; imm=S; mem_en=1; ram_mode={f3,1}; rd=0.
  - BRANCH 1100011: reg_we=0; a_sel=1; b_sel=1; imm=B; is_branch=1; br_type=f3; rd=0.
  - JALR 1100111: b_sel=1; imm=I; write_sel=10; is_jump=1.
  - JAL 1101111: a_sel=1; b_sel=1; imm=J; write_sel=10; is_jump=1.
  - LUI 0110111: b_sel=1; imm=U; rs1 forced to 0.
  - AUIPC 0010111: a_sel=1; b_sel=1; imm=U.
  - Any other opcode: illegal=1; reg_we=0; mem_en=0; the entry still passes downstream.
  - Defaults for all instructions: reg_we=1; other fields 0 unless set above.
- Rule for rd==0: reg_we is forced to 0.
- Buffer FSM: EMPTY -> ONE on accept. ONE -> TWO on accept without out handshake. TWO -> ONE on out handshake. ONE -> EMPTY on out handshake without accept. Accept and out handshake in the same cycle in ONE keeps ONE, with the new entry replacing the old.
- in_ready is low in TWO. in_ready is registered apart from the hazard term.
- out_* must hold stable while out_valid && !out_ready. Entries leave in order: the output entry first, then the skid entry.
- Hazard (LOAD_USE_STALL=1):
  - Condition: a buffered entry has mem_en && !is_store && rd!=0, and in_inst uses rs1 or rs2 equal to that rd.
  - rs1 counts as used by OP, OP-IMM, LOAD, STORE, BRANCH and JALR.
  - rs2 counts as used by OP, STORE and BRANCH.
  - While the condition holds, in_ready=0 (combinational from in_inst). The hold clears the cycle after that load's out handshake.
- Flush:
  - Has priority over every other event.
  - Next cycle: state EMPTY, out_valid=0, pending tags cleared.
  - in_ready=0 during the flush cycle, so no instruction is captured.
  - An out handshake in the flush cycle still counts as delivered.
- Reset asserted mid-transfer: same as flush, and all fields return to 0.

Test Plan:
- After reset, in_inst=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, rd=1, imm=5, alu=0000, b_sel=1, reg_we=1.
- out_ready=0, push 3 instructions back-to-back -> two accepted, in_ready=0 on the third. Raise out_ready -> entries drain in order with no loss or duplication.
- lw x5,0(x2) followed by add x6,x5,x1 with LOAD_USE_STALL=1 -> add is held until the cycle after lw leaves. With LOAD_USE_STALL=0 there is no hold.
- srai x3,x3,4 (0x4041D193) -> alu=1011. addi with imm[10]=1 -> alu=0000. beq with negative offset -> imm sign-extended to XLEN, br_type=000, reg_we=0.
- Buffer in TWO, assert flush with in_valid=1 -> next cycle out_valid=0, the in instruction is not captured, and a new instruction is accepted one cycle later.
- Unknown opcode 0x0000007F -> illegal=1, reg_we=0, mem_en=0. addi x0,x0,1 -> reg_we=0. XLEN=64 with lui 0x80000 -> imm=0xFFFFFFFF80000000.
